// File: rtl/mt9d111_axis_capture.sv
// mt9d111_axis_capture
//   Capture stage for the MT9D111 parallel camera port. Registers
//   vsync/href/data, pairs bytes into RGB565 pixels, expands them to RGB888
//   and emits an AXI4-Stream video stream through a first-word-fall-through
//   FIFO. The camera cannot be stalled, so back-pressure beyond the FIFO
//   drops pixels and raises a sticky overflow flag.
//
// Ports
//   axis_aclk      camera pclk, all logic on the rising edge
//   axis_aresetn   asynchronous active-low reset
//   capture_en     level enable for frame capture
//   cam_vsync      high while a frame is in progress
//   cam_href       high while line bytes are valid
//   cam_data       byte stream, {R5,G6[5:3]} then {G6[2:0],B5}
//   m_axis_*       AXI4-Stream master: tdata={R8,G8,B8}, tuser=SOF, tlast=EOL
//   overflow       sticky, a pixel was dropped on a full FIFO
//   size_err       sticky, line/frame length mismatch or odd byte count
//   frame_count    completed frames, wraps
module mt9d111_axis_capture #(
  parameter int HORIZONTAL_PIXELS = 800,
  parameter int VERTICAL_LINES    = 600,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        size_err,
  output logic [15:0] frame_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] H_PIX   = 16'(HORIZONTAL_PIXELS);
  localparam logic [15:0] V_LINES = 16'(VERTICAL_LINES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT_SOF, S_IN_FRAME} state_t;

  function automatic logic [23:0] expand565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  state_t      r_state;
  logic        r_v_p0, r_h_p0, r_v_p1, r_h_p1;
  logic [7:0]  r_d_p0;
  logic        r_phase, r_hold_vld, r_sof_pending;
  logic [7:0]  r_first;
  logic [23:0] r_hold;
  logic [15:0] r_line, r_pix;
  logic        r_push_vld;
  logic [25:0] r_push_ent;
  logic        r_size_err, r_overflow;
  logic [15:0] r_frame_count;
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [25:0] r_mem [FIFO_DEPTH];

  logic        w_in_frame, w_byte0, w_byte1, w_h_fall, w_v_rise, w_v_fall;
  logic        w_push_mid, w_push_end;
  logic        w_empty, w_full, w_pop, w_wr;
  logic [25:0] w_head;

  assign w_in_frame = (r_state == S_IN_FRAME);
  assign w_byte0    = w_in_frame & r_h_p0 & ~r_phase;
  assign w_byte1    = w_in_frame & r_h_p0 &  r_phase;
  assign w_h_fall   = w_in_frame & ~r_h_p0 & r_h_p1;
  assign w_v_rise   =  r_v_p0 & ~r_v_p1;
  assign w_v_fall   = ~r_v_p0 &  r_v_p1;
  // Held pixel leaves when its successor completes (tlast=0) or the line ends (tlast=1).
  assign w_push_mid = w_byte1  & r_hold_vld;
  assign w_push_end = w_h_fall & r_hold_vld;

  // Stage p0: camera inputs registered; stage p1: edge-detect reference
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_v_p0 <= 1'b0;
      r_h_p0 <= 1'b0;
      r_v_p1 <= 1'b0;
      r_h_p1 <= 1'b0;
    end else begin
      r_v_p0 <= cam_vsync;
      r_h_p0 <= cam_href;
      r_v_p1 <= r_v_p0;
      r_h_p1 <= r_h_p0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    r_d_p0 <= cam_data;
    if (w_byte0) r_first <= r_d_p0;
    if (w_byte1) r_hold <= expand565({r_first, r_d_p0});
    if (w_push_mid || w_push_end) r_push_ent <= {r_sof_pending, w_push_end, r_hold};
  end

  // Frame FSM, byte phase, hold-register bookkeeping and push request
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state       <= S_IDLE;
      r_phase       <= 1'b0;
      r_hold_vld    <= 1'b0;
      r_sof_pending <= 1'b0;
      r_line        <= '0;
      r_pix         <= '0;
      r_push_vld    <= 1'b0;
      r_size_err    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_push_vld <= w_push_mid | w_push_end;
      if (w_push_mid || w_push_end) r_sof_pending <= 1'b0;
      case (r_state)
        S_IDLE: if (capture_en) r_state <= S_ARM;
        // Never start mid-frame: wait for vsync to be low first.
        S_ARM: if (!r_v_p0) r_state <= S_WAIT_SOF;
        S_WAIT_SOF: begin
          if (w_v_rise) begin
            r_state       <= S_IN_FRAME;
            r_sof_pending <= 1'b1;
            r_line        <= '0;
            r_pix         <= '0;
            r_phase       <= 1'b0;
            r_hold_vld    <= 1'b0;
          end
        end
        S_IN_FRAME: begin
          if (r_h_p0) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              r_hold_vld <= 1'b1;
              r_pix      <= r_pix + 16'd1;
            end
          end else begin
            r_phase <= 1'b0;
            if (r_h_p1) begin
              // Line end: a set phase means a dangling odd byte, which is dropped.
              r_hold_vld <= 1'b0;
              r_line     <= r_line + 16'd1;
              r_pix      <= '0;
              if (r_phase || (r_pix != H_PIX)) r_size_err <= 1'b1;
            end
          end
          if (w_v_fall) begin
            if (r_line != V_LINES) r_size_err <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_hold_vld    <= 1'b0;
            r_state       <= capture_en ? S_WAIT_SOF : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & m_axis_tready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = r_push_vld & (~w_full | w_pop);

  // FIFO stage: pointers and overflow flag
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_push_vld && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_push_ent;
  end

  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_empty ? 24'd0 : w_head[23:0];
  assign m_axis_tlast  = ~w_empty & w_head[24];
  assign m_axis_tuser  = ~w_empty & w_head[25];
  assign overflow      = r_overflow;
  assign size_err      = r_size_err;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_mt9d111_axis_capture.sv
module tb_mt9d111_axis_capture;

  logic        clk = 1'b0;
  logic        axis_aresetn;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic        size_err;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  logic [7:0]  fixed_q[$];
  bit          m_sof;

  always #5 clk = ~clk;

  mt9d111_axis_capture #(
    .HORIZONTAL_PIXELS(4),
    .VERTICAL_LINES   (3),
    .FIFO_DEPTH       (16)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (axis_aresetn),
    .capture_en   (capture_en),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .overflow     (overflow),
    .size_err     (size_err),
    .frame_count  (frame_count)
  );

  // Collect every accepted beat; inputs change only just after posedge.
  always @(negedge clk) begin
    if (axis_aresetn && m_axis_tvalid && m_axis_tready)
      got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RGB565 bytes to RGB888 by scaling each channel to 8 bits with MSB refill.
  function automatic logic [23:0] model_rgb(input logic [7:0] b0, input logic [7:0] b1);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(b0) / 8;
    g6 = (int'(b0) % 8) * 8 + int'(b1) / 32;
    b5 = int'(b1) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  task automatic do_reset();
    axis_aresetn = 1'b0;
    repeat (2) tick();
    axis_aresetn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    fixed_q.delete();
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    m_sof     = 1'b1;
    repeat (3) tick();
  endtask

  task automatic frame_end();
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (6) tick();
  endtask

  // Drive one line; when rec is set, append the beats the camera line should produce.
  task automatic cam_line(input int nbytes, input bit rec);
    logic [7:0] bl[$];
    logic [7:0] b;
    int np;
    for (int i = 0; i < nbytes; i++) begin
      if (fixed_q.size() > 0) b = fixed_q.pop_front();
      else b = 8'($urandom_range(0, 255));
      bl.push_back(b);
      cam_href = 1'b1;
      cam_data = b;
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'($urandom_range(0, 255));
    repeat (4) tick();
    if (rec) begin
      np = nbytes / 2;
      for (int k = 0; k < np; k++) begin
        exp_q.push_back({m_sof, (k == np - 1), model_rgb(bl[2*k], bl[2*k+1])});
        m_sof = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    axis_aresetn = 1'b0;
    tick();
    n_tests++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, size_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00000",
               {m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, size_err});
    end
    n_tests++;
    if (m_axis_tdata !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_tdata got=%h exp=000000", m_axis_tdata);
    end
    n_tests++;
    if (frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_count got=%0d exp=0", frame_count);
    end
    axis_aresetn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_sync();
    clear_queues();
    capture_en = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    frame_begin();
    for (int l = 0; l < 3; l++) cam_line(8, 1'b1);
    frame_end();
    repeat (10) tick();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL sync_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sync_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (frame_count !== 16'd1 || size_err !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_status got fc=%0d se=%b of=%b exp fc=1 se=0 of=0",
               frame_count, size_err, overflow);
    end
    frame_begin();
    for (int l = 0; l < 3; l++) cam_line(8, 1'b1);
    frame_end();
    n_tests++;
    if (frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL sync_frame_count2 got=%0d exp=2", frame_count);
    end
  endtask

  task automatic test_pairing();
    logic [23:0] want[3];
    want[0] = 24'hFF00FF;
    want[1] = 24'h00FF00;
    want[2] = 24'h000000;
    clear_queues();
    capture_en = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    fixed_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h00};
    frame_begin();
    for (int l = 0; l < 3; l++) cam_line(8, 1'b1);
    frame_end();
    repeat (10) tick();
    n_tests++;
    if (got_q.size() < 3) begin
      n_fail++;
      $display("FAIL pair_count got=%0d exp>=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got_q[i][23:0] !== want[i]) begin
          n_fail++;
          $display("FAIL pair_rgb%0d got=%h exp=%h", i, got_q[i][23:0], want[i]);
        end
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pair_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_partial_frame();
    clear_queues();
    capture_en = 1'b1;
    m_axis_tready = 1'b1;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    axis_aresetn = 1'b0;
    repeat (2) tick();
    axis_aresetn = 1'b1;
    tick();
    cam_line(8, 1'b0);
    cam_line(8, 1'b0);
    frame_end();
    frame_begin();
    for (int l = 0; l < 3; l++) cam_line(8, 1'b1);
    frame_end();
    repeat (10) tick();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL partial_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    n_tests++;
    if (got_q.size() == 0 || got_q[0][25] !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_first_tuser got_beats=%0d exp first tuser=1", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL partial_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    clear_queues();
    capture_en = 1'b1;
    m_axis_tready = 1'b0;
    do_reset();
    frame_begin();
    for (int l = 0; l < 10; l++) cam_line(8, 1'b1);
    frame_end();
    n_tests++;
    if (got_q.size() !== 0 || m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall got beats=%0d tvalid=%b exp beats=0 tvalid=1",
               got_q.size(), m_axis_tvalid);
    end
    n_tests++;
    if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_head got=%h exp=%h",
               {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overflow got=%b exp=1", overflow);
    end
    m_axis_tready = 1'b1;
    repeat (40) tick();
    n_tests++;
    if (got_q.size() !== 16) begin
      n_fail++;
      $display("FAIL bp_drain_count got=%0d exp=16", got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_size_err();
    int lens[2][3];
    lens[0] = '{8, 6, 8};
    lens[1] = '{8, 7, 8};
    for (int c = 0; c < 2; c++) begin
      clear_queues();
      capture_en = 1'b1;
      m_axis_tready = 1'b1;
      do_reset();
      frame_begin();
      for (int l = 0; l < 3; l++) cam_line(lens[c][l], 1'b1);
      frame_end();
      repeat (10) tick();
      n_tests++;
      if (size_err !== 1'b1) begin
        n_fail++;
        $display("FAIL size_err_case%0d got=%b exp=1", c, size_err);
      end
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL size_count_case%0d got=%0d exp=%0d", c, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL size_beat%0d_case%0d got=%h exp=%h", i, c, got_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (got_q.size() < 7 || got_q[6][24] !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_line_tlast got_beats=%0d exp beat6 tlast=1", got_q.size());
    end
  endtask

  task automatic test_capture_en_drop();
    clear_queues();
    capture_en = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    frame_begin();
    cam_line(8, 1'b1);
    capture_en = 1'b0;
    cam_line(8, 1'b1);
    cam_line(8, 1'b1);
    frame_end();
    frame_begin();
    for (int l = 0; l < 3; l++) cam_line(8, 1'b0);
    frame_end();
    repeat (10) tick();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL capen_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL capen_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL capen_frame_count got=%0d exp=1", frame_count);
    end
  endtask

  initial begin
    axis_aresetn  = 1'b0;
    capture_en    = 1'b0;
    cam_vsync     = 1'b0;
    cam_href      = 1'b0;
    cam_data      = 8'd0;
    m_axis_tready = 1'b0;
    m_sof         = 1'b0;
    test_reset();
    test_sync();
    test_pairing();
    test_partial_frame();
    test_back_pressure();
    test_size_err();
    test_capture_en_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
